// File: rtl/ra_builder.sv
// Region Array builder: writes one control word plus per-list OL pointers per tile.
// Optional RA_BUILDER_CHECKSUM_EN adds a running XOR of all accepted write data.
module ra_builder #(
  parameter int          ADDR_W     = 24,
  parameter logic [31:0] PTR_UNUSED = 32'h8000_0000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ra_gen_trig,
  input  logic [31:0]       REGION_BASE,
  input  logic [31:0]       OL_BASE,
  input  logic [31:0]       TA_ALLOC_CTRL,
  input  logic [31:0]       TA_GLOB_TILE_CLIP,
  input  logic [31:0]       FPU_PARAM_CFG,
  input  logic              cfg_zkeep,
  input  logic              vram_wait,
  output logic              ra_vram_wr,
  output logic [ADDR_W-1:0] ra_vram_addr,
  output logic [31:0]       ra_vram_dout,
  output logic              busy,
  output logic              done
`ifdef RA_BUILDER_CHECKSUM_EN
  ,
  output logic [31:0]       ra_checksum
`endif
);

  typedef enum logic [1:0] {
    IDLE, SETUP, WRITE, DONE
  } state_t;

  state_t            state;
  logic [2:0]        step;
  logic [2:0]        widx;
  logic [ADDR_W-1:0] region;
  logic [ADDR_W-1:0] acc;
  logic [ADDR_W-1:0] ptr [5];
  logic [1:0]        opb_n [5];
  logic [5:0]        tx_max;
  logic [3:0]        ty_max;
  logic [5:0]        tile_x;
  logic [3:0]        tile_y;
  logic [10:0]       ntiles;
  logic              v2;
  logic              zkeep;

  logic              last_word;
  logic              last_tile;
  logic              nx_last;
  logic [5:0]        nx_x;
  logic [3:0]        nx_y;
  logic [31:0]       ptr_word;

  logic unused_bits;
  assign unused_bits = ^{REGION_BASE[31:ADDR_W], REGION_BASE[1:0],
    OL_BASE[31:ADDR_W], OL_BASE[1:0], TA_ALLOC_CTRL[31:18],
    TA_ALLOC_CTRL[15:14], TA_ALLOC_CTRL[11:10], TA_ALLOC_CTRL[7:6],
    TA_ALLOC_CTRL[3:2], TA_GLOB_TILE_CLIP[31:20],
    TA_GLOB_TILE_CLIP[15:6], FPU_PARAM_CFG[31:22], FPU_PARAM_CFG[20:0]};

  function automatic logic [31:0] ctrl_word(
    input logic       last,
    input logic [3:0] y,
    input logic [5:0] x
  );
    return {last, zkeep, 2'b00, 14'b0, 2'b00, y, x, 2'b00};
  endfunction

  // Bytes one list type occupies across all tiles; disabled lists take none.
  function automatic logic [ADDR_W-1:0] span(input logic [1:0] n);
    if (n == 2'd0) return '0;
    return ADDR_W'({ntiles, 4'b0}) << n;
  endfunction

  always_comb begin
    last_word = widx == (v2 ? 3'd5 : 3'd4);
    last_tile = (tile_x == tx_max) && (tile_y == ty_max);
    nx_x = tile_x + 6'd1;
    nx_y = tile_y;
    if (tile_x == tx_max) begin
      nx_x = 6'd0;
      nx_y = tile_y + 4'd1;
    end
    nx_last = (nx_x == tx_max) && (nx_y == ty_max);
    ptr_word = PTR_UNUSED;
    for (int k = 0; k < 5; k++) begin
      if (3'(k) == widx && opb_n[k] != 2'd0) ptr_word = 32'(ptr[k]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      step         <= '0;
      widx         <= '0;
      region       <= '0;
      acc          <= '0;
      tx_max       <= '0;
      ty_max       <= '0;
      tile_x       <= '0;
      tile_y       <= '0;
      ntiles       <= '0;
      v2           <= 1'b0;
      zkeep        <= 1'b0;
      ra_vram_wr   <= 1'b0;
      ra_vram_addr <= '0;
      ra_vram_dout <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      for (int k = 0; k < 5; k++) begin
        ptr[k]   <= '0;
        opb_n[k] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (ra_gen_trig) begin
            region <= {REGION_BASE[ADDR_W-1:2], 2'b00};
            acc    <= {OL_BASE[ADDR_W-1:2], 2'b00};
            tx_max <= TA_GLOB_TILE_CLIP[5:0];
            ty_max <= TA_GLOB_TILE_CLIP[19:16];
            v2     <= FPU_PARAM_CFG[21];
            zkeep  <= cfg_zkeep;
            for (int k = 0; k < 5; k++) begin
              opb_n[k] <= TA_ALLOC_CTRL[4*k +: 2];
            end
            step  <= '0;
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          step <= step + 3'd1;
          if (step == 3'd0) begin
            ntiles <= 11'((11'(tx_max) + 11'd1) * (11'(ty_max) + 11'd1));
          end
          for (int k = 0; k < 5; k++) begin
            if (3'(k + 1) == step) begin
              ptr[k] <= acc;
              acc    <= acc + span(opb_n[k]);
            end
          end
          if (step == 3'd5) begin
            tile_x       <= '0;
            tile_y       <= '0;
            widx         <= '0;
            ra_vram_wr   <= 1'b1;
            ra_vram_addr <= region;
            ra_vram_dout <= ctrl_word(tx_max == 6'd0 && ty_max == 4'd0,
                                      4'd0, 6'd0);
            state        <= WRITE;
          end
        end
        WRITE: begin
          if (!vram_wait) begin
            ra_vram_addr <= ra_vram_addr + ADDR_W'(4);
            if (last_word) begin
              widx <= '0;
              for (int k = 0; k < 5; k++) begin
                if (opb_n[k] != 2'd0) ptr[k] <= ptr[k] + (ADDR_W'(16) << opb_n[k]);
              end
              if (last_tile) begin
                ra_vram_wr <= 1'b0;
                done       <= 1'b1;
                state      <= DONE;
              end else begin
                tile_x       <= nx_x;
                tile_y       <= nx_y;
                ra_vram_dout <= ctrl_word(nx_last, nx_y, nx_x);
              end
            end else begin
              widx         <= widx + 3'd1;
              ra_vram_dout <= ptr_word;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RA_BUILDER_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ra_checksum <= '0;
    end else if (state == IDLE && ra_gen_trig) begin
      ra_checksum <= '0;
    end else if (state == WRITE && !vram_wait) begin
      ra_checksum <= ra_checksum ^ ra_vram_dout;
    end
  end
`endif

endmodule
